// File: rtl/bram_stream_reader_if.sv
// Output stream bundle of bram_stream_reader: valid/ready handshake with data and
// end-of-transfer marker. The master drives the words, the slave accepts them.
interface bram_stream_reader_if #(
    parameter int RAM_WIDTH = 32
);
    logic                 out_valid;
    logic                 out_ready;
    logic [RAM_WIDTH-1:0] out_data;
    logic                 out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Reads a run of consecutive words from a single-port BRAM and replays them on a
// valid/ready stream, buffering the 1-cycle read latency and backpressure in a FIFO.
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    bram_stream_reader_if.master     out_s
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [RAM_ADDR_BITS:0]   issue_rem_q, issue_rem_d;
    logic [RAM_ADDR_BITS:0]   out_rem_q, out_rem_d;
    logic                     pending_q, pending_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [RAM_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];

    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     fifo_valid;
    logic [CNT_W:0]           credit_used;

    // Words already buffered plus the read still in flight; same-cycle pops earn no credit.
    assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
    assign fifo_valid  = (count_q != '0);
    assign issue       = (state_q == S_READ) && (credit_used < DEPTH_C);
    assign push        = pending_q;
    assign pop         = fifo_valid && out_s.out_ready;

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign ram_enable   = issue;
    assign write_enable = 1'b0;
    assign address      = addr_q;

    assign out_s.out_valid = fifo_valid;
    assign out_s.out_data  = fifo_valid ? fifo_mem[rd_ptr_q] : '0;
    assign out_s.out_last  = fifo_valid && (out_rem_q == (RAM_ADDR_BITS+1)'(1));

    // NOTE: every signal gets a default first so no path through the case leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        out_rem_d   = out_rem_q;
        pending_d   = issue;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            out_rem_d = out_rem_q - (RAM_ADDR_BITS+1)'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    issue_rem_d = length;
                    out_rem_d   = length;
                    state_d     = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d      = addr_q + RAM_ADDR_BITS'(1);
                    issue_rem_d = issue_rem_q - (RAM_ADDR_BITS+1)'(1);
                    if (issue_rem_q == (RAM_ADDR_BITS+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the out_last word is accepted so done follows it directly.
                if ((out_rem_q == '0) || (pop && out_rem_q == (RAM_ADDR_BITS+1)'(1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            out_rem_q   <= '0;
            pending_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            out_rem_q   <= out_rem_d;
            pending_q   <= pending_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the reset counters
    // and out_data is masked while empty, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= ram_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && push && !pop) begin
            assert (count_q != CNT_W'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: a behavioural BRAM, a queue of expected
// words built from memory contents at start time, and a negedge monitor.
module tb_bram_stream_reader;

    localparam int W     = 32;
    localparam int AB    = 9;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << AB;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AB-1:0] base_addr;
    logic [AB:0]   length;
    logic          busy, done, ram_enable, write_enable;
    logic [AB-1:0] address;
    logic [W-1:0]  ram_data;

    bram_stream_reader_if #(.RAM_WIDTH(W)) s_if ();

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .ram_enable  (ram_enable),
        .write_enable(write_enable),
        .address     (address),
        .ram_data    (ram_data),
        .out_s       (s_if)
    );

    always #5 clock = ~clock;

    logic [W-1:0] mem [WORDS];
    always @(posedge clock) begin
        if (ram_enable) ram_data <= mem[address];
    end

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   addr_q[$];
    int   issued, popped, done_cnt;
    int   start_cyc, exp_done_cyc, first_hs, last_hs;
    bit   first_pending;
    int   ready_mode;
    int   pat_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = fixed toggle pattern, 3 = held low.
    initial begin
        s_if.out_ready = 1'b1;
        pat_idx = 0;
        forever begin
            @(posedge clock);
            #1;
            pat_idx++;
            case (ready_mode)
                0: s_if.out_ready = 1'b1;
                1: s_if.out_ready = 1'($urandom_range(0, 1));
                2: s_if.out_ready = (pat_idx % 6 == 0) || (pat_idx % 6 == 3) || (pat_idx % 6 == 5);
                default: s_if.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit           prev_stall = 0;
        logic [W-1:0] prev_data  = '0;
        exp_t         e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_stall = 0;
                continue;
            end
            if (ram_enable) begin
                check("write_enable_low", 64'(write_enable), 64'd0);
                if (addr_q.size() == 0) check("spurious_issue", 64'd1, 64'd0);
                else check("issue_addr", 64'(address), 64'(addr_q.pop_front()));
                issued++;
                check("credit_limit", 64'(issued - popped <= DEPTH), 64'd1);
            end
            if (prev_stall) begin
                check("stall_valid", 64'(s_if.out_valid), 64'd1);
                check("stall_data", 64'(s_if.out_data), 64'(prev_data));
            end
            if (s_if.out_valid && first_pending) begin
                check("first_valid_cycle", 64'(cyc), 64'(start_cyc + 2));
                first_pending = 0;
            end
            if (s_if.out_valid) begin
                if (exp_q.size() == 0) check("spurious_valid", 64'd1, 64'd0);
                else if (s_if.out_ready) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(s_if.out_data), 64'(e.data));
                    check("out_last", 64'(s_if.out_last), 64'(e.last));
                    popped++;
                    if (popped == 1) first_hs = cyc;
                    last_hs = cyc;
                    if (e.last) exp_done_cyc = cyc + 1;
                end
            end
            if (done) begin
                check("done_cycle", 64'(cyc), 64'(exp_done_cyc));
                done_cnt++;
                exp_done_cyc = -1;
            end
            prev_stall = s_if.out_valid && !s_if.out_ready;
            prev_data  = s_if.out_data;
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        first_pending = 0;
        exp_done_cyc  = -1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic launch(input int base, input int len, input int mode);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.data = mem[(base + i) % WORDS];
            e.last = (i == len - 1);
            exp_q.push_back(e);
            addr_q.push_back((base + i) % WORDS);
        end
        issued = 0;
        popped = 0;
        ready_mode = mode;
        @(negedge clock);
        start_cyc     = cyc + 1;
        first_pending = (len != 0);
        exp_done_cyc  = (len == 0) ? start_cyc : -1;
        start     = 1'b1;
        base_addr = AB'(base);
        length    = (AB+1)'(len);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int len, input int d0);
        int n = 0;
        int bound = len * 10 + 100;
        while (done_cnt == d0 && n < bound) begin
            @(posedge clock);
            n++;
        end
        check("done_seen", 64'(done_cnt != d0), 64'd1);
        @(negedge clock);
        check("busy_after_done", 64'(busy), 64'd0);
        check("all_words_out", 64'(exp_q.size()), 64'd0);
        if (done_cnt == d0) apply_reset();
    endtask

    task automatic xfer(input int base, input int len, input int mode);
        int d0 = done_cnt;
        launch(base, len, mode);
        wait_done(len, d0);
    endtask

    initial begin
        int d0;
        int n;
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        ready_mode = 0;
        issued = 0; popped = 0; done_cnt = 0;
        exp_done_cyc = -1;
        first_pending = 0;
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ram_enable", 64'(ram_enable), 64'd0);
        check("rst_valid", 64'(s_if.out_valid), 64'd0);
        check("rst_last", 64'(s_if.out_last), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_data", 64'(s_if.out_data), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) mem[i] = W'(i * 10);
        xfer(0, 20, 0);
        check("throughput_span", 64'(last_hs - first_hs), 64'd19);

        xfer(5, 3, 2);

        // Backpressure: issue must stop at the FIFO depth, then resume cleanly.
        d0 = done_cnt;
        launch(0, 10, 3);
        repeat (20) @(negedge clock);
        check("stalled_issue_count", 64'(issued), 64'(DEPTH));
        check("stalled_ram_enable", 64'(ram_enable), 64'd0);
        ready_mode = 0;
        wait_done(10, d0);

        mem[510] = 7; mem[511] = 8; mem[0] = 9;
        xfer(510, 3, 0);

        xfer(0, 0, 0);

        // A start pulse while busy must be ignored.
        mem[0] = 0;
        d0 = done_cnt;
        launch(0, 8, 0);
        repeat (2) @(negedge clock);
        check("busy_mid_xfer", 64'(busy), 64'd1);
        start = 1'b1; base_addr = AB'(100); length = (AB+1)'(5);
        @(negedge clock);
        start = 1'b0;
        wait_done(8, d0);

        // Reset mid-transfer: outputs clear at once, no done pulse, fresh start works.
        d0 = done_cnt;
        launch(0, 20, 0);
        n = 0;
        while (popped < 3 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ram_enable", 64'(ram_enable), 64'd0);
        check("midrst_valid", 64'(s_if.out_valid), 64'd0);
        check("midrst_last", 64'(s_if.out_last), 64'd0);
        check("midrst_address", 64'(address), 64'd0);
        check("midrst_data", 64'(s_if.out_data), 64'd0);
        exp_q.delete();
        addr_q.delete();
        first_pending = 0;
        exp_done_cyc = -1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("midrst_no_done", 64'(done_cnt), 64'(d0));
        xfer(0, 2, 0);

        // Randomized transfers over random memory contents.
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        for (int t = 0; t < 10; t++) begin
            xfer(int'($urandom_range(0, WORDS - 1)), int'($urandom_range(1, 40)),
                 int'($urandom_range(0, 2)));
        end
        xfer(int'($urandom_range(0, WORDS - 1)), WORDS, 1);
        xfer(int'($urandom_range(0, WORDS - 1)), 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side master for the single-port `bram` block; it drives that block's clock-domain port (ram_enable, write_enable, address) and consumes output_data.
- On a start command it reads `length` consecutive words from `base_addr` upward.
- It returns the words on a valid/ready stream with out_last, absorbing the BRAM's 1-cycle read latency and downstream backpressure in a small output FIFO.

Parameters:
- RAM_WIDTH, 32, data word width; matches bram RAM_WIDTH.
- RAM_ADDR_BITS, 9, BRAM address width; matches bram RAM_ADDR_BITS.
- FIFO_DEPTH, 4, output FIFO entries; legal values are powers of two >= 4.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  RAM_ADDR_BITS  first BRAM address of the transfer.
- length  input  RAM_ADDR_BITS+1  word count, 0..2^RAM_ADDR_BITS.
- busy  output  1  high from start acceptance until the done pulse, inclusive.
- done  output  1  single-cycle completion pulse.
- ram_enable  output  1  to bram ram_enable.
- write_enable  output  1  to bram write_enable; constant 0.
- address  output  RAM_ADDR_BITS  to bram address.
- ram_data  input  RAM_WIDTH  from bram output_data; valid in the cycle after a read is issued.
- out_valid  output  1  stream data valid.
- out_ready  input  1  downstream accept.
- out_data  output  RAM_WIDTH  stream word (FIFO head).
- out_last  output  1  marks the final word of the transfer.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - busy, done, ram_enable, out_valid, out_last = 0.
  - address = 0; out_data = 0.
  - FIFO emptied; all counters cleared.
  - Reset mid-transfer discards any in-flight read and all buffered words; no done pulse is produced.
- State machine IDLE / READ / DRAIN / DONE:
  - IDLE:
    - start=1 at an edge latches base_addr into the address counter and length into remaining-issue and remaining-output counters; busy=1.
    - Go to READ if length != 0.
    - Go to DONE if length == 0; no reads are issued and no stream words are produced.
  - READ: issue one read per cycle when the credit rule passes.
    - After the last read is issued, go to DRAIN.
  - DRAIN: wait until the output counter reaches 0, i.e. the out_last word has been handshaken, then go to DONE.
  - DONE: done=1 for exactly one cycle; busy stays 1 during this cycle; then go to IDLE.
    - Earliest next start acceptance is at the edge that leaves DONE.
- Read issue:
  - A read is issued in a cycle when ram_enable=1 and address=current counter; the bram samples them at the end of that cycle.
  - Credit rule: issue only when fifo_count + pending + 1 <= FIFO_DEPTH.
    - fifo_count is the registered occupancy at the start of the cycle.
    - pending = 1 if a read was issued in the previous cycle, otherwise 0.
    - Pops in the current cycle are not credited.
  - The address increments modulo 2^RAM_ADDR_BITS after each issue (511 wraps to 0).
  - ram_enable=0 in every non-issue cycle.
- Data capture:
  - ram_data is written into the FIFO at the end of the cycle following an issue.
  - The FIFO never overflows under the credit rule; overflow is an assertion failure.
- Stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A word pops when out_valid && out_ready.
  - out_last=1 when the head word is the final word of the transfer.
  - out_valid may not drop while out_ready=0.
  - out_data is stable while out_valid && !out_ready.
- Latency:
  - start sampled at edge E0 → read of base_addr issued in cycle E0–E1.
  - ram_data valid E1–E2.
  - out_valid=1 after E2.
  - With out_ready held high, throughput is 1 word/cycle.
  - done pulses in the cycle after the out_last handshake.
- Boundaries:
  - start while busy is ignored, and base_addr/length are not re-sampled.
  - length = 2^RAM_ADDR_BITS reads the whole memory exactly once, beginning at base_addr and wrapping.
  - out_ready held low: at most FIFO_DEPTH words are issued, then issue stalls; issue resumes without loss or duplication.

Test Plan:
- Preload bram addresses 0..19 with addr*10; start with base=0, length=20, out_ready=1 → out_data 0,10,...,190 on 20 consecutive cycles; first out_valid 2 edges after the start edge; out_last on 190; done pulse on the next cycle; busy low after that.
- base=5, length=3, out_ready toggling 1,0,0,1,0,1... → exactly 50,60,70 delivered in order; out_data stable during stalls; ram_enable issues never exceed FIFO_DEPTH ahead of pops.
- out_ready=0 for 20 cycles with length=10 → exactly 4 reads issued, then ram_enable=0; releasing out_ready yields all 10 words, no gaps in value.
- Preload addresses 510, 511, 0 with 7, 8, 9; base=510, length=3 → address sequence 510, 511, 0; data 7, 8, 9; out_last on 9.
- length=0 → no ram_enable, no out_valid; done pulses one cycle after the start edge; a start pulse during busy of a length=8 transfer → ignored, exactly 8 words out.
- reset_n pulsed low mid-transfer (after 3 words) → all outputs 0 immediately, no done pulse; a fresh start (base=0, length=2) then returns 0,10 correctly.
